// File: rtl/riscv_multicycle_core.sv
// riscv_multicycle_core: multicycle RV-subset integer core with req/ack instruction and data ports.
// Define CPU_ILLEGAL_TRAP_EN to halt on illegal opcodes/shamts; otherwise they retire as NOPs.
module riscv_multicycle_core #(
  parameter int XLEN = 64,
  parameter int NREGS = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            retire,
  output logic            halted
);
  localparam int RW = $clog2(NREGS);
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011,
    OP_IMM = 7'b0010011, OP_OP = 7'b0110011, OP_JAL = 7'b1101111, OP_LUI = 7'b0110111;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t r_state, w_next;
  logic [XLEN-1:0] r_pc, r_a, r_b, r_alu, r_mdr;
  logic [31:0] r_ir;
  logic [XLEN-1:0] r_rf [NREGS];
  logic [6:0] w_opc;
  logic [2:0] w_f3;
  logic [RW-1:0] w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u, w_op2, w_alu;
  logic signed [XLEN-1:0] w_sra;
  logic [5:0] w_sh;
  logic w_take, w_shift_bad, w_illegal, w_store;
  assign w_opc = r_ir[6:0];
  assign w_f3 = r_ir[14:12];
  // RV-E drops index bit 4 by taking only the low RW bits
  assign w_rs1 = r_ir[15 +: RW];
  assign w_rs2 = r_ir[20 +: RW];
  assign w_rd = r_ir[7 +: RW];
  assign w_imm_i = XLEN'($signed(r_ir[31:20]));
  assign w_imm_s = XLEN'($signed({r_ir[31:25], r_ir[11:7]}));
  assign w_imm_b = XLEN'($signed({r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0}));
  assign w_imm_j = XLEN'($signed({r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0}));
  assign w_imm_u = XLEN'($signed({r_ir[31:12], 12'b0}));
  assign w_op2 = (w_opc == OP_OP) ? r_b : w_imm_i;
  assign w_sh = (XLEN == 64) ? w_op2[5:0] : {1'b0, w_op2[4:0]};
  assign w_sra = $signed(r_a) >>> w_sh;
  assign w_alu = (w_opc == OP_LUI) ? w_imm_u :
    (w_f3 == 3'd0) ? ((w_opc == OP_OP && r_ir[30]) ? r_a - w_op2 : r_a + w_op2) :
    (w_f3 == 3'd1) ? r_a << w_sh :
    (w_f3 == 3'd2) ? XLEN'($signed(r_a) < $signed(w_op2)) :
    (w_f3 == 3'd3) ? XLEN'(r_a < w_op2) :
    (w_f3 == 3'd4) ? r_a ^ w_op2 :
    (w_f3 == 3'd5) ? (r_ir[30] ? $unsigned(w_sra) : r_a >> w_sh) :
    (w_f3 == 3'd6) ? r_a | w_op2 : r_a & w_op2;
  assign w_take = (w_f3 == 3'd0) ? r_a == r_b :
    (w_f3 == 3'd1) ? r_a != r_b :
    (w_f3 == 3'd4) ? $signed(r_a) < $signed(r_b) :
    (w_f3 == 3'd5) ? $signed(r_a) >= $signed(r_b) :
    (w_f3 == 3'd6) ? r_a < r_b :
    (w_f3 == 3'd7) ? r_a >= r_b : 1'b0;
  assign w_shift_bad = (XLEN == 32) && w_opc == OP_IMM && w_f3[1:0] == 2'b01 && r_ir[25];
  assign w_illegal = w_shift_bad ||
    !(w_opc inside {OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM, OP_OP, OP_JAL, OP_LUI});
  assign w_store = w_opc == OP_STORE;
  // requests drop combinationally with reset so an in-flight handshake is abandoned at once
  assign imem_req = reset_n && r_state == S_FETCH;
  assign imem_addr = r_pc;
  assign dmem_req = reset_n && r_state == S_MEM;
  assign dmem_we = dmem_req && w_store;
  assign dmem_addr = r_alu;
  assign dmem_wdata = r_b;
`ifdef CPU_ILLEGAL_TRAP_EN
  assign halted = r_state == S_HALT;
`else
  assign halted = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    retire = 1'b0;
    case (r_state)
      S_FETCH: w_next = imem_ack ? S_DECODE : S_FETCH;
      S_DECODE: w_next = S_EXEC;
      S_EXEC: begin
        if (w_illegal) begin
`ifdef CPU_ILLEGAL_TRAP_EN
          w_next = S_HALT;
`else
          w_next = S_FETCH;
          retire = 1'b1;
`endif
        end else if (w_opc == OP_BRANCH) begin
          w_next = S_FETCH;
          retire = 1'b1;
        end else begin
          w_next = (w_opc == OP_LOAD || w_store) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        w_next = !dmem_ack ? S_MEM : w_store ? S_FETCH : S_WB;
        retire = dmem_ack && w_store;
      end
      S_WB: begin
        w_next = S_FETCH;
        retire = 1'b1;
      end
      default: w_next = r_state;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_FETCH;
      r_pc <= RESET_PC;
      r_ir <= '0;
      r_a <= '0;
      r_b <= '0;
      r_alu <= '0;
      r_mdr <= '0;
      for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_FETCH: if (imem_ack) begin
          r_ir <= imem_rdata;
          r_pc <= r_pc + FOUR;
        end
        S_DECODE: begin
          r_a <= r_rf[w_rs1];
          r_b <= r_rf[w_rs2];
          r_alu <= r_pc - FOUR + ((w_opc == OP_JAL) ? w_imm_j : w_imm_b);
        end
        S_EXEC: begin
          if (w_illegal) begin
`ifdef CPU_ILLEGAL_TRAP_EN
            r_pc <= r_pc - FOUR;
`endif
          end else if (w_opc == OP_LOAD) r_alu <= r_a + w_imm_i;
          else if (w_store) r_alu <= r_a + w_imm_s;
          else if (w_opc == OP_BRANCH) begin
            if (w_take) r_pc <= r_alu;
          end else if (w_opc == OP_JAL) begin
            r_alu <= r_pc;
            r_pc <= r_alu;
          end else r_alu <= w_alu;
        end
        S_MEM: if (dmem_ack && !w_store) r_mdr <= dmem_rdata;
        S_WB: if (w_rd != '0) r_rf[w_rd] <= (w_opc == OP_LOAD) ? r_mdr : r_alu;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_multicycle_core.sv
// tb_riscv_multicycle_core: table-driven ALU/branch vectors plus directed handshake, JAL, reset and illegal-opcode sequences.
// Results are observed through stores on the data port; CPU_ILLEGAL_TRAP_EN selects the trap expectations.
module tb_riscv_multicycle_core;
  logic clock = 1'b0, reset_n = 1'b0;
  logic imem_req, imem_ack = 1'b0, dmem_req, dmem_we, dmem_ack = 1'b0, retire, halted;
  logic [63:0] imem_addr, dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] imem [0:255];
  logic [63:0] dmem [0:127];
  logic [63:0] st_addr [$], st_data [$], fetch_addr [$];
  int ret_cyc [$];
  int iwait = 0, dwait = 0, icnt = 0, dcnt = 0, cyc = 0;
  int checks = 0, failures = 0;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] exp;
  } vec_t;
  vec_t vecs [$];

  riscv_multicycle_core #(.XLEN(64), .NREGS(32), .RESET_PC(64'h0)) dut (
    .clock(clock), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .retire(retire), .halted(halted)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= reset_n ? cyc + 1 : 0;

  // memories answer on the falling edge so the core sees stable acks at the next rising edge
  always @(negedge clock) begin
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    if (imem_req) begin
      if (icnt >= iwait) begin
        imem_ack = 1'b1;
        imem_rdata = imem[imem_addr[9:2]];
        fetch_addr.push_back(imem_addr);
        icnt = 0;
      end else icnt++;
    end else icnt = 0;
    if (dmem_req) begin
      if (dcnt >= dwait) begin
        dmem_ack = 1'b1;
        if (dmem_we) begin
          dmem[dmem_addr[9:3]] = dmem_wdata;
          st_addr.push_back(dmem_addr);
          st_data.push_back(dmem_wdata);
        end else dmem_rdata = dmem[dmem_addr[9:3]];
        dcnt = 0;
      end else dcnt++;
    end else dcnt = 0;
  end

  always @(negedge clock) begin
    #1;
    if (reset_n && retire) ret_cyc.push_back(cyc + 1);
  end

  function automatic logic [31:0] op_i(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic logic [31:0] op_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] op_sd(input logic [11:0] imm, input logic [4:0] rs2);
    return {imm[11:5], rs2, 5'd0, 3'b011, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] op_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] op_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic hold_reset();
    @(posedge clock);
    #1 reset_n = 1'b0;
    st_addr.delete();
    st_data.delete();
    fetch_addr.delete();
    ret_cyc.delete();
    iwait = 0;
    dwait = 0;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000006F;
    for (int i = 0; i < 128; i++) dmem[i] = '0;
  endtask

  task automatic release_reset();
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_stores(input int n, input string nm);
    int k = 0;
    while (st_data.size() < n && k < 400) begin
      @(posedge clock);
      k++;
    end
    checks++;
    if (st_data.size() < n) begin
      failures++;
      $display("FAIL %s timeout: stores=%0d required=%0d", nm, st_data.size(), n);
    end
  endtask

  initial begin
    vecs.push_back('{op_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 64'd2});
    vecs.push_back('{op_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd3), 64'hFFFF_FFFF_FFFF_FFF8});
    vecs.push_back('{op_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd3), 64'd1});
    vecs.push_back('{op_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd3), 64'd0});
    vecs.push_back('{op_r(7'h00, 5'd2, 5'd1, 3'b100, 5'd3), 64'hFFFF_FFFF_FFFF_FFF8});
    vecs.push_back('{op_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd3), 64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{op_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd3), 64'd5});
    vecs.push_back('{op_r(7'h00, 5'd1, 5'd1, 3'b001, 5'd3), 64'hA0});
    vecs.push_back('{op_r(7'h00, 5'd1, 5'd2, 3'b101, 5'd3), 64'h07FF_FFFF_FFFF_FFFF});
    vecs.push_back('{op_r(7'h20, 5'd1, 5'd2, 3'b101, 5'd3), 64'hFFFF_FFFF_FFFF_FFFF});
    vecs.push_back('{op_i(12'h401, 5'd2, 3'b101, 5'd3, 7'b0010011), 64'hFFFF_FFFF_FFFF_FFFE});
    vecs.push_back('{op_i(12'h03E, 5'd1, 3'b001, 5'd3, 7'b0010011), 64'h4000_0000_0000_0000});
    vecs.push_back('{op_i(12'h03C, 5'd2, 3'b101, 5'd3, 7'b0010011), 64'hF});
    vecs.push_back('{op_i(12'hFFF, 5'd1, 3'b011, 5'd3, 7'b0010011), 64'd1});
    vecs.push_back('{op_i(12'hFFF, 5'd1, 3'b010, 5'd3, 7'b0010011), 64'd0});
    vecs.push_back('{op_i(12'hFFF, 5'd2, 3'b100, 5'd3, 7'b0010011), 64'd2});
    vecs.push_back('{op_i(12'h0F0, 5'd1, 3'b110, 5'd3, 7'b0010011), 64'hF5});
    vecs.push_back('{{20'h80000, 5'd3, 7'b0110111}, 64'hFFFF_FFFF_8000_0000});
    // branches skip to a store of x2 when taken, otherwise store the untouched x3
    vecs.push_back('{op_b(13'd8, 5'd1, 5'd2, 3'b110), 64'd0});
    vecs.push_back('{op_b(13'd8, 5'd1, 5'd2, 3'b100), 64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{op_b(13'd8, 5'd1, 5'd1, 3'b000), 64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{op_b(13'd8, 5'd1, 5'd1, 3'b001), 64'd0});
    vecs.push_back('{op_b(13'd8, 5'd2, 5'd1, 3'b101), 64'hFFFF_FFFF_FFFF_FFFD});
    vecs.push_back('{op_b(13'd8, 5'd2, 5'd1, 3'b111), 64'd0});

    hold_reset();
    #2;
    check("rst_imem_req", {63'd0, imem_req}, 64'd0);
    check("rst_dmem_req", {63'd0, dmem_req}, 64'd0);
    check("rst_retire", {63'd0, retire}, 64'd0);
    check("rst_dmem_addr", dmem_addr, 64'd0);
    release_reset();
    @(negedge clock);
    #2;
    check("rel_imem_req", {63'd0, imem_req}, 64'd1);
    check("rel_imem_addr", imem_addr, 64'd0);

    for (int v = 0; v < vecs.size(); v++) begin
      hold_reset();
      imem[0] = op_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
      imem[1] = op_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'b0010011);
      imem[2] = vecs[v].ins;
      imem[3] = op_sd(12'd0, 5'd3);
      imem[4] = op_sd(12'd0, 5'd2);
      release_reset();
      wait_stores(1, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_data", v), st_data[0], vecs[v].exp);
    end

    hold_reset();
    imem[0] = op_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
    imem[1] = op_i(12'hFFD, 5'd0, 3'b000, 5'd2, 7'b0010011);
    imem[2] = op_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    imem[3] = op_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd4);
    imem[4] = op_sd(12'd8, 5'd3);
    imem[5] = op_i(12'd8, 5'd0, 3'b011, 5'd5, 7'b0000011);
    imem[6] = op_sd(12'd24, 5'd5);
    imem[7] = op_sd(12'd16, 5'd4);
    dwait = 3;
    release_reset();
    wait_stores(3, "memseq");
    check("alu4_cycles", 64'(ret_cyc[3]), 64'd16);
    check("store_wait_cycles", 64'(ret_cyc[4] - ret_cyc[3]), 64'd7);
    check("load_wait_cycles", 64'(ret_cyc[5] - ret_cyc[4]), 64'd8);
    check("sd_addr", st_addr[0], 64'd8);
    check("sd_data", st_data[0], 64'd2);
    check("ld_data", st_data[1], 64'd2);
    check("sub_data", st_data[2], 64'hFFFF_FFFF_FFFF_FFF8);

    hold_reset();
    imem[0] = op_i(12'd7, 5'd0, 3'b000, 5'd0, 7'b0010011);
    imem[1] = op_sd(12'd32, 5'd0);
    imem[2] = op_i(12'd0, 5'd0, 3'b000, 5'd0, 7'b0010011);
    imem[3] = op_sd(12'd0, 5'd1);
    imem[4] = op_j(21'h1FFFFC, 5'd1);
    release_reset();
    wait_stores(3, "jalseq");
    check("x0_addr", st_addr[0], 64'd32);
    check("x0_data", st_data[0], 64'd0);
    check("jal_link", st_data[2], 64'h14);
    check("jal_target", fetch_addr[5], 64'h0C);

    iwait = 1000;
    repeat (10) @(posedge clock);
    #2;
    check("stall_req", {63'd0, imem_req}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("async_req_drop", {63'd0, imem_req}, 64'd0);
    check("async_pc", imem_addr, 64'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    #2;
    check("rerel_req", {63'd0, imem_req}, 64'd1);
    check("rerel_addr", imem_addr, 64'd0);

    hold_reset();
    imem[0] = op_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
    imem[1] = 32'h0000007F;
    imem[2] = op_sd(12'd0, 5'd1);
    release_reset();
`ifdef CPU_ILLEGAL_TRAP_EN
    repeat (20) @(posedge clock);
    #2;
    check("trap_halted", {63'd0, halted}, 64'd1);
    check("trap_pc", imem_addr, 64'd4);
    check("trap_no_req", {63'd0, imem_req}, 64'd0);
    check("trap_retires", 64'(ret_cyc.size()), 64'd1);
    check("trap_no_store", 64'(st_data.size()), 64'd0);
`else
    wait_stores(1, "nopseq");
    check("nop_retire_cycle", 64'(ret_cyc[1]), 64'd7);
    check("nop_next_fetch", fetch_addr[2], 64'd8);
    check("nop_store", st_data[0], 64'd5);
    check("nop_halted", {63'd0, halted}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/riscv_multicycle_core.md
Name: riscv_multicycle_core

Overview:
Parametrised multicycle RV-subset integer core and the next generation of the team's single-file multicycle CPU. It is generalised in XLEN and register count. It moves memory out of the core onto separate instruction and data ports with req/ack handshakes, so wait states are supported. It adds the full base ALU, all six branch compares, JAL and LUI. It sits under the SoC top, with imem/dmem wired to BRAM or bus bridges.

Parameters:
XLEN, 64, datapath and register width; legal values 32 or 64.
NREGS, 32, architectural register count; legal values 16 (RV-E) or 32; r0 is hardwired to 0.
RESET_PC, 0, PC value loaded at reset.

Ports:
clock  in  1  core clock, rising edge.
reset_n  in  1  asynchronous active-low reset.
imem_req  out  1  fetch request, held until imem_ack.
imem_addr  out  XLEN  byte address of fetch, equal to PC.
imem_rdata  in  32  instruction word, valid when imem_ack=1.
imem_ack  in  1  fetch completes this cycle.
dmem_req  out  1  data request, held until dmem_ack.
dmem_we  out  1  1=store, 0=load; stable while dmem_req=1.
dmem_addr  out  XLEN  effective byte address rs1+imm.
dmem_wdata  out  XLEN  store data, equal to rs2.
dmem_rdata  in  XLEN  load data, valid when dmem_ack=1.
dmem_ack  in  1  data access completes this cycle.
retire  out  1  one-cycle pulse per completed instruction.
halted  out  1  core stopped; sticky until reset.

Behaviour:
- Reset (async assert, sync release): PC=RESET_PC, state=FETCH, all regs=0, imem_req=1 on the first cycle after release. All other outputs 0.
- Instruction encodings:
  - LOAD 0000011 and STORE 0100011: full XLEN word; funct3 ignored.
  - BRANCH 1100011: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - OP-IMM 0010011: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - OP 0110011: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - JAL 1101111 and LUI 0110111.
- FETCH: assert imem_req with imem_addr=PC. On imem_ack: IR<=imem_rdata, PC<=PC+4, go to DECODE. Without ack, stay (unbounded wait).
- DECODE: A<=R[rs1], B<=R[rs2], ALUOut<=oldPC+B-imm (PC-4+imm). Go to EXEC.
- EXEC:
  - LOAD/STORE: ALUOut<=A+I/S-imm, go to MEM.
  - OP/OP-IMM/LUI: compute ALUOut, go to WB.
  - BRANCH: if taken, PC<=ALUOut; retire=1; go to FETCH.
  - JAL: ALUOut<=PC (link), PC<=target; go to WB.
  - Illegal opcode: see the optional feature.
- MEM: dmem_req=1, dmem_addr=ALUOut, dmem_we=STORE.
  - Store: complete on dmem_ack, retire, go to FETCH.
  - Load: on dmem_ack, MDR<=dmem_rdata, go to WB.
- WB: R[rd]<=ALUOut or MDR; a write to r0 is discarded. retire=1, go to FETCH.
- Latency with zero-wait memory: ALU/JAL/LUI 4 cycles; branch 3; store 4; load 5. Each wait cycle adds one.
- Arithmetic:
  - Immediates are sign-extended to XLEN.
  - Shift amount is B[5:0] when XLEN=64 and B[4:0] when XLEN=32.
  - For SLLI/SRLI/SRAI with XLEN=32, imm[5]=1 is illegal.
  - SUB and SRA are selected by funct7[5].
  - PC arithmetic wraps modulo 2^XLEN.
- Misaligned access: the low address bits are passed through unchanged; the memory is responsible for it.
- NREGS=16: rs/rd index bit 4 is ignored.
- Reset asserted mid-request: req drops immediately. A late ack after reset is ignored, because the core is in FETCH with a fresh req.
- An ack arriving while req=0 is ignored.

Optional Feature:
CPU_ILLEGAL_TRAP_EN
- Defined: an unknown opcode (or an illegal shamt) in EXEC moves to HALT. halted=1, PC is frozen at the faulting address (PC-4 restored), no further req is issued, and retire stays 0. Only reset exits HALT.
- Undefined: an unknown opcode is executed as a NOP. retire=1, go to FETCH. halted is tied to 0.

Test Plan:
- Program ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1, zero-wait -> x3=2, x4=-8 (all ones except 3'b000 low), 4 retire pulses, 16 cycles.
- SD x3,8(x0) then LD x5,8(x0) with dmem_ack delayed 3 cycles -> dmem_wdata=2 at addr 8, x5=2, store takes 7 cycles and load 8.
- BLTU x2,x1,+8 with x2=-3, x1=5 -> not taken, PC advances by 4. BLT with the same operands -> taken to PC+8.
- JAL x1,-4 at PC 0x10 -> x1=0x14, next fetch address 0x0C. Write to x0 via ADDI x0,x0,7 -> x0 reads back 0.
- Pulse reset_n low while imem_req waits for ack -> imem_req falls asynchronously. After release, imem_addr=RESET_PC.
- Opcode 0x7F with CPU_ILLEGAL_TRAP_EN -> halted=1 and PC equals the faulting address. Without the macro -> one retire pulse and the next fetch is at PC+4.
